wfg_stim_sine_ctrl: RTL and testbench
=====================================

# wfg_stim_sine_ctrl

Sequencing controller for the CORDIC sine stimulus core. It paces sample requests to the core at a programmable sample rate and runs either continuous or fixed-length bursts. It captures each one-cycle core result into an AXI-Stream output register, and reports busy, completion and late-sample status. It sits between the register file and the sine core, and its stream output feeds the downstream SPI/driver stage.

## Interface
- CNT_W, 16, width of burst-length, sample-count and clock-divider fields
- DATA_W, 18, sample width (matches sine core output)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_en_i  in  1  block enable; low acts as stop
- cfg_start_i  in  1  start pulse; ignored unless IDLE and cfg_en_i=1
- cfg_stop_i  in  1  stop pulse
- cfg_mode_i  in  1  0 = continuous, 1 = burst
- cfg_burst_len_i  in  CNT_W  samples per burst
- cfg_clkdiv_i  in  CNT_W  sample period minus one, in clk cycles
- sine_en_o  out  1  to core ctrl_en; one-cycle request pulse
- sine_tready_o  out  1  to core tready
- sine_tvalid_i  in  1  core result valid (one-cycle pulse)
- sine_tdata_i  in  DATA_W  core result (signed)
- stim_tvalid_o  out  1  downstream valid
- stim_tready_i  in  1  downstream ready
- stim_tdata_o  out  DATA_W  downstream sample
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse at burst completion
- late_o  out  1  sticky; a sample tick arrived before the previous sample was delivered
- sample_cnt_o  out  CNT_W  samples accepted downstream in the current run

## Operation
- States: IDLE, WAIT_TICK, REQ, HOLD, DRAIN.
- IDLE:
  - On cfg_start_i && cfg_en_i: clear sample_cnt_o and late_o, restart the tick timer, go to REQ.
  - Exception: burst mode with cfg_burst_len_i=0 pulses done_o and stays in IDLE.
- REQ:
  - sine_en_o is high for the first REQ cycle only.
  - sine_tready_o is high throughout REQ.
  - On sine_tvalid_i: capture sine_tdata_i into stim_tdata_o, set stim_tvalid_o, go to HOLD.
- HOLD:
  - stim_tvalid_o is held high and stim_tdata_o held stable until stim_tvalid_o && stim_tready_i.
  - On acceptance, sample_cnt_o increments.
  - If burst mode and the new count equals cfg_burst_len_i: pulse done_o, go to IDLE.
  - Otherwise go to WAIT_TICK, or directly to REQ if a tick is pending.
- WAIT_TICK: go to REQ on the tick.
- Tick timer:
  - Free-running counter, reloaded at start; a tick fires every cfg_clkdiv_i+1 cycles.
  - A tick that arrives in REQ or HOLD sets late_o and is latched as one pending tick. Further ticks are dropped.
- Stop (cfg_stop_i pulse or cfg_en_i low):
  - In WAIT_TICK: go to IDLE next cycle.
  - In REQ: go to DRAIN. DRAIN keeps sine_tready_o high, waits for sine_tvalid_i, discards the sample, then goes to IDLE. This keeps the core phase-consistent.
  - In HOLD: complete the pending handshake, then go to IDLE. An AXI valid is never withdrawn.
  - done_o is not pulsed on stop.
- Continuous mode: sample_cnt_o wraps modulo 2^CNT_W.
- Configuration inputs are sampled at start. cfg_clkdiv_i may change mid-run and takes effect at the next reload.
- sine_tready_o is low outside REQ and DRAIN. The core therefore parks in its DONE state and does not advance phase until the controller accepts.

## Timing
- Reset: all outputs 0, state IDLE, pending tick cleared.
- Start to sine_en_o: 1 cycle (start sampled at edge N, sine_en_o high in cycle N+1).
- sine_tvalid_i to stim_tvalid_o: 1 cycle (registered capture).
- stim_tready_i in the cycle stim_tvalid_o is high completes the transfer at that edge. done_o follows one cycle later, and busy_o falls in the same cycle as done_o.
- The controller makes no assumption about core latency (nominally 19 cycles). It waits on sine_tvalid_i.
- Simultaneous start and stop in IDLE: stop wins; the block stays in IDLE.
- Reset mid-run: IDLE next cycle. The core must be reset together with the controller.

## Structure
- Package wfg_stim_sine_ctrl_pkg: state enum wfg_stim_sine_ctrl_states_t, mode constants MODE_CONT/MODE_BURST, default CNT_W/DATA_W.
- Sub-module wfg_stim_sine_ctrl_timer: reloadable divider producing the tick, plus the pending-tick and late logic.

## Test plan
- Burst, len=3, clkdiv=39, stim_tready_i tied high, core model latency 19:
  - exactly 3 samples, spaced 40 cycles;
  - done_o single pulse; sample_cnt_o=3; late_o=0.
- clkdiv=4, continuous:
  - late_o set on the first tick during REQ;
  - samples back-to-back with no tick starvation; at most one pending tick.
- Downstream backpressure, stim_tready_i low for 50 cycles in HOLD:
  - stim_tdata_o stable, stim_tvalid_o held;
  - sine_tready_o low throughout, so the core does not advance.
- cfg_stop_i in REQ, 5 cycles after sine_en_o:
  - DRAIN until sine_tvalid_i;
  - no stim_tvalid_o, no done_o, IDLE afterwards.
- Burst with len=0:
  - done_o pulse one cycle after start, no sine_en_o.
- Continuous run of 65537 samples:
  - sample_cnt_o wraps to 1.
- rst asserted in HOLD:
  - all outputs 0 next cycle.

Source files
------------

// File: rtl/wfg_stim_sine_ctrl_pkg.sv
// wfg_stim_sine_ctrl_pkg: shared states, modes and default widths for the sine sequencing controller
package wfg_stim_sine_ctrl_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int DATA_W_DEF = 18;
  localparam logic MODE_CONT = 1'b0;
  localparam logic MODE_BURST = 1'b1;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT_TICK, ST_REQ, ST_HOLD, ST_DRAIN} wfg_stim_sine_ctrl_states_t;
endpackage

// File: rtl/wfg_stim_sine_ctrl_if.sv
// wfg_stim_sine_ctrl_if: AXI-Stream sample link from the controller to the downstream driver stage
interface wfg_stim_sine_ctrl_if import wfg_stim_sine_ctrl_pkg::*; #(parameter int DATA_W = DATA_W_DEF);
  logic stim_tvalid_o;
  logic stim_tready_i;
  logic [DATA_W-1:0] stim_tdata_o;
  modport master(output stim_tvalid_o, stim_tdata_o, input stim_tready_i);
  modport slave(input stim_tvalid_o, stim_tdata_o, output stim_tready_i);
endinterface

// File: rtl/wfg_stim_sine_ctrl_timer.sv
// wfg_stim_sine_ctrl_timer: reloadable sample-rate divider with one-deep pending tick and sticky late flag
module wfg_stim_sine_ctrl_timer #(parameter int CNT_W = 16) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_reload,
  input  logic             i_clear,
  input  logic             i_exposed,
  input  logic             i_consume,
  input  logic [CNT_W-1:0] i_clkdiv,
  output logic             o_tick,
  output logic             o_pend,
  output logic             o_late
);
  logic [CNT_W-1:0] r_cnt;
  logic r_pend, r_late;
  assign o_tick = r_cnt == '0;
  assign o_pend = r_pend;
  assign o_late = r_late;
  // down-counter; the divisor is re-read on every reload so mid-run changes land at the next tick
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else r_cnt <= (i_reload | o_tick) ? i_clkdiv : r_cnt - 1'b1;
  // a tick landing while a sample is still in flight is remembered once and flagged as late
  always_ff @(posedge clk)
    if (rst | i_reload) begin
      r_pend <= 1'b0;
      r_late <= 1'b0;
    end else begin
      r_pend <= (i_clear | i_consume) ? 1'b0 : (o_tick & i_exposed) ? 1'b1 : r_pend;
      r_late <= r_late | (o_tick & i_exposed);
    end
endmodule

// File: rtl/wfg_stim_sine_ctrl.sv
// wfg_stim_sine_ctrl: paces sine core requests, captures results into an AXI-Stream register, tracks run status
module wfg_stim_sine_ctrl import wfg_stim_sine_ctrl_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en_i,
  input  logic              cfg_start_i,
  input  logic              cfg_stop_i,
  input  logic              cfg_mode_i,
  input  logic [CNT_W-1:0]  cfg_burst_len_i,
  input  logic [CNT_W-1:0]  cfg_clkdiv_i,
  output logic              sine_en_o,
  output logic              sine_tready_o,
  input  logic              sine_tvalid_i,
  input  logic [DATA_W-1:0] sine_tdata_i,
  wfg_stim_sine_ctrl_if.master stim,
  output logic              busy_o,
  output logic              done_o,
  output logic              late_o,
  output logic [CNT_W-1:0]  sample_cnt_o
);
  wfg_stim_sine_ctrl_states_t r_state, w_next;
  logic r_mode, r_sine_en, r_tvalid, r_done, r_stop_hold;
  logic [CNT_W-1:0] r_len, r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_data;
  logic w_stop, w_halt, w_start, w_zero_burst, w_reload, w_accept, w_last, w_capture, w_done;
  logic w_tick, w_pend, w_late;
  assign w_stop = cfg_stop_i | ~cfg_en_i;
  assign w_halt = w_stop | r_stop_hold;
  assign w_start = cfg_start_i & ~w_stop;
  assign w_zero_burst = cfg_mode_i == MODE_BURST && cfg_burst_len_i == '0;
  assign w_reload = r_state == ST_IDLE && w_start && !w_zero_burst;
  assign w_accept = r_state == ST_HOLD && stim.stim_tready_i;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_last = r_mode == MODE_BURST && w_cnt_nxt == r_len;
  assign w_capture = r_state == ST_REQ && sine_tvalid_i && !w_stop;
  assign sine_en_o = r_sine_en;
  assign sine_tready_o = r_state == ST_REQ || r_state == ST_DRAIN;
  assign stim.stim_tvalid_o = r_tvalid;
  assign stim.stim_tdata_o = r_data;
  assign busy_o = r_state != ST_IDLE;
  assign done_o = r_done;
  assign late_o = w_late;
  assign sample_cnt_o = r_cnt;
  wfg_stim_sine_ctrl_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_reload (w_reload),
    .i_clear  (r_state == ST_IDLE),
    .i_exposed(r_state == ST_REQ || r_state == ST_HOLD),
    .i_consume(w_accept && w_next == ST_REQ),
    .i_clkdiv (cfg_clkdiv_i),
    .o_tick   (w_tick),
    .o_pend   (w_pend),
    .o_late   (w_late)
  );
  // state register
  always_ff @(posedge clk) r_state <= rst ? ST_IDLE : w_next;
  // next state; a stop seen in REQ still waits for the core result so the core stays phase-aligned
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next = w_reload ? ST_REQ : ST_IDLE;
        w_done = w_start && w_zero_burst;
      end
      ST_WAIT_TICK: w_next = w_stop ? ST_IDLE : w_tick ? ST_REQ : ST_WAIT_TICK;
      ST_REQ: w_next = sine_tvalid_i ? (w_stop ? ST_IDLE : ST_HOLD) : (w_stop ? ST_DRAIN : ST_REQ);
      ST_HOLD: begin
        w_next = !w_accept ? ST_HOLD : (w_halt || w_last) ? ST_IDLE : (w_pend || w_tick) ? ST_REQ : ST_WAIT_TICK;
        w_done = w_accept && !w_halt && w_last;
      end
      ST_DRAIN: w_next = sine_tvalid_i ? ST_IDLE : ST_DRAIN;
      default: w_next = ST_IDLE;
    endcase
  end
  // run configuration, sample counter, output stream register and request/done pulses
  always_ff @(posedge clk)
    if (rst) begin
      r_mode <= MODE_CONT;
      r_len <= '0;
      r_cnt <= '0;
      r_data <= '0;
      r_tvalid <= 1'b0;
      r_sine_en <= 1'b0;
      r_done <= 1'b0;
      r_stop_hold <= 1'b0;
    end else begin
      r_sine_en <= w_next == ST_REQ && r_state != ST_REQ;
      r_done <= w_done;
      r_stop_hold <= r_state == ST_HOLD && !w_accept && w_halt;
      r_mode <= w_reload ? cfg_mode_i : r_mode;
      r_len <= w_reload ? cfg_burst_len_i : r_len;
      r_cnt <= w_reload ? '0 : w_accept ? w_cnt_nxt : r_cnt;
      r_data <= w_capture ? sine_tdata_i : r_data;
      r_tvalid <= w_capture ? 1'b1 : w_accept ? 1'b0 : r_tvalid;
    end
endmodule

// File: tb/tb_wfg_stim_sine_ctrl.sv
// tb_wfg_stim_sine_ctrl: directed checks of pacing, bursts, backpressure, stop, wrap and reset
module tb_wfg_stim_sine_ctrl;
  import wfg_stim_sine_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_en_i = 1'b0, cfg_start_i = 1'b0, cfg_stop_i = 1'b0, cfg_mode_i = 1'b0;
  logic [7:0] cfg_burst_len_i = '0, cfg_clkdiv_i = '0;
  logic sine_en_o, sine_tready_o, sine_tvalid_i;
  logic [17:0] sine_tdata_i;
  logic busy_o, done_o, late_o;
  logic [7:0] sample_cnt_o;
  logic [17:0] core_val = 18'h2A5A5, core_last = '0, d0;
  int core_lat = 19, core_cnt = 0;
  int tests = 0, fails = 0;
  int t, n_acc, n_tv, n_done, done_t, data_err, bad;
  logic done_busy;
  int en_q[$];
  wfg_stim_sine_ctrl_if #(.DATA_W(18)) sif();
  wfg_stim_sine_ctrl #(.CNT_W(8), .DATA_W(18)) dut (
    .clk(clk), .rst(rst), .cfg_en_i(cfg_en_i), .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i),
    .cfg_mode_i(cfg_mode_i), .cfg_burst_len_i(cfg_burst_len_i), .cfg_clkdiv_i(cfg_clkdiv_i),
    .sine_en_o(sine_en_o), .sine_tready_o(sine_tready_o), .sine_tvalid_i(sine_tvalid_i),
    .sine_tdata_i(sine_tdata_i), .stim(sif), .busy_o(busy_o), .done_o(done_o), .late_o(late_o),
    .sample_cnt_o(sample_cnt_o)
  );
  initial forever #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  // core model: one-cycle result pulse core_lat cycles after each request
  initial begin
    sine_tvalid_i = 1'b0;
    sine_tdata_i = '0;
    forever begin
      @(negedge clk);
      sine_tvalid_i = 1'b0;
      if (rst) core_cnt = 0;
      else begin
        if (core_cnt > 0) begin
          core_cnt--;
          if (core_cnt == 0) begin
            core_val = core_val + 18'h01357;
            sine_tdata_i = core_val;
            core_last = core_val;
            sine_tvalid_i = 1'b1;
          end
        end
        if (sine_en_o) core_cnt = core_lat;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic clr();
    t = 0; n_acc = 0; n_tv = 0; n_done = 0; done_t = -1; data_err = 0; done_busy = 1'b1;
    en_q.delete();
  endtask
  task automatic step();
    @(negedge clk);
    t++;
    if (sine_en_o) en_q.push_back(t);
    if (sif.stim_tvalid_o) n_tv++;
    if (sif.stim_tvalid_o && sif.stim_tready_i) begin
      n_acc++;
      if (sif.stim_tdata_o !== core_last) data_err++;
    end
    if (done_o) begin
      n_done++;
      done_t = t;
      done_busy = busy_o;
    end
  endtask
  task automatic start_run(input logic mode, input logic [7:0] len, input logic [7:0] div);
    cfg_mode_i = mode;
    cfg_burst_len_i = len;
    cfg_clkdiv_i = div;
    cfg_start_i = 1'b1;
    clr();
    step();
    cfg_start_i = 1'b0;
  endtask
  task automatic stop_pulse();
    cfg_stop_i = 1'b1;
    step();
    cfg_stop_i = 1'b0;
  endtask
  initial begin
    sif.stim_tready_i = 1'b1;
    clr();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cfg_en_i = 1'b1;
    step();
    chk("rst_busy", busy_o, 0);
    chk("rst_outputs", {sine_en_o, sine_tready_o, sif.stim_tvalid_o, done_o, late_o}, 0);
    chk("rst_cnt", sample_cnt_o, 0);
    chk("rst_tdata", sif.stim_tdata_o, 0);
    // burst of 3 at 40-cycle period
    start_run(MODE_BURST, 8'd3, 8'd39);
    chk("t1_first_en", sine_en_o, 1);
    repeat (119) step();
    chk("t1_n_en", en_q.size(), 3);
    chk("t1_gap1", en_q[1] - en_q[0], 40);
    chk("t1_gap2", en_q[2] - en_q[1], 40);
    chk("t1_n_acc", n_acc, 3);
    chk("t1_n_done", n_done, 1);
    chk("t1_done_cycle", done_t, 102);
    chk("t1_busy_at_done", done_busy, 0);
    chk("t1_cnt", sample_cnt_o, 3);
    chk("t1_late", late_o, 0);
    chk("t1_data", data_err, 0);
    // fast continuous: ticks outrun the core, samples go back to back
    start_run(MODE_CONT, 8'd0, 8'd4);
    repeat (4) step();
    chk("t2_late_before_tick", late_o, 0);
    step();
    chk("t2_late_after_tick", late_o, 1);
    repeat (124) step();
    chk("t2_n_en", en_q.size(), 7);
    bad = 0;
    for (int i = 1; i < en_q.size(); i++) if (en_q[i] - en_q[i-1] != 21) bad++;
    chk("t2_gaps", bad, 0);
    chk("t2_n_acc", n_acc, 6);
    chk("t2_n_done", n_done, 0);
    chk("t2_data", data_err, 0);
    stop_pulse();
    repeat (40) step();
    chk("t2_stopped", busy_o, 0);
    // downstream backpressure for 50 cycles in HOLD
    sif.stim_tready_i = 1'b0;
    core_lat = 2;
    start_run(MODE_CONT, 8'd0, 8'd9);
    for (int i = 0; i < 10 && !sif.stim_tvalid_o; i++) step();
    chk("t3_capture_cycle", t, 4);
    chk("t3_capture_data", sif.stim_tdata_o, core_last);
    d0 = sif.stim_tdata_o;
    bad = 0;
    repeat (50) begin
      step();
      if (sif.stim_tvalid_o !== 1'b1 || sif.stim_tdata_o !== d0 || sine_tready_o !== 1'b0 || sine_en_o !== 1'b0) bad++;
    end
    chk("t3_hold_stable", bad, 0);
    chk("t3_late", late_o, 1);
    sif.stim_tready_i = 1'b1;
    clr();
    repeat (15) step();
    chk("t3_n_en", en_q.size(), 2);
    chk("t3_pending_en", en_q[0], 1);
    chk("t3_single_pending", en_q[1], 7);
    chk("t3_n_acc", n_acc, 2);
    stop_pulse();
    repeat (5) step();
    chk("t3_stopped", busy_o, 0);
    // stop in REQ five cycles after the request: drain, no output
    core_lat = 19;
    start_run(MODE_BURST, 8'd5, 8'd39);
    repeat (5) step();
    stop_pulse();
    repeat (13) step();
    chk("t4_drain_busy", busy_o, 1);
    chk("t4_drain_tready", sine_tready_o, 1);
    step();
    chk("t4_idle", busy_o, 0);
    repeat (30) step();
    chk("t4_n_tv", n_tv, 0);
    chk("t4_n_done", n_done, 0);
    chk("t4_n_en", en_q.size(), 1);
    chk("t4_tready_idle", sine_tready_o, 0);
    // start with stop, and start while disabled, are both ignored
    clr();
    cfg_start_i = 1'b1;
    cfg_stop_i = 1'b1;
    step();
    cfg_start_i = 1'b0;
    cfg_stop_i = 1'b0;
    chk("t5_start_stop", {busy_o, sine_en_o}, 0);
    cfg_en_i = 1'b0;
    cfg_start_i = 1'b1;
    step();
    cfg_start_i = 1'b0;
    cfg_en_i = 1'b1;
    chk("t5_start_disabled", {busy_o, sine_en_o}, 0);
    // zero-length burst
    start_run(MODE_BURST, 8'd0, 8'd39);
    chk("t6_done", done_o, 1);
    chk("t6_busy", busy_o, 0);
    chk("t6_no_en", sine_en_o, 0);
    step();
    chk("t6_done_single", done_o, 0);
    repeat (25) step();
    chk("t6_n_en", en_q.size(), 0);
    // counter wrap: 257 samples on an 8-bit counter
    core_lat = 1;
    start_run(MODE_CONT, 8'd0, 8'd0);
    for (int i = 0; i < 3000 && n_acc < 257; i++) step();
    chk("t7_n_acc", n_acc, 257);
    chk("t7_cnt_at_256", sample_cnt_o, 0);
    step();
    chk("t7_cnt_wrap", sample_cnt_o, 1);
    chk("t7_data", data_err, 0);
    stop_pulse();
    repeat (10) step();
    chk("t7_stopped", busy_o, 0);
    // reset while holding a sample
    sif.stim_tready_i = 1'b0;
    core_lat = 2;
    start_run(MODE_CONT, 8'd0, 8'd1);
    for (int i = 0; i < 10 && !sif.stim_tvalid_o; i++) step();
    chk("t8_in_hold", sif.stim_tvalid_o, 1);
    chk("t8_late_before", late_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t8_rst_busy", busy_o, 0);
    chk("t8_rst_flags", {sine_en_o, sine_tready_o, sif.stim_tvalid_o, done_o, late_o}, 0);
    chk("t8_rst_tdata", sif.stim_tdata_o, 0);
    chk("t8_rst_cnt", sample_cnt_o, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
